// File: rtl/interrupt_sequencer_if.sv
// Bus bundle between the interrupt sequencer, the priority interrupt controller
// (INT/INTACK/INTV), the return-PC stack port and the fetch redirect.
interface interrupt_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              INT;
    logic              INTACK;
    logic [2:0]        INTV;
    logic              push_valid;
    logic [ADDR_W-1:0] push_data;
    logic              push_ready;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;

    modport master (
        input  INT, INTV, push_ready,
        output INTACK, push_valid, push_data, jump_valid, jump_addr
    );

    modport slave (
        output INT, INTV, push_ready,
        input  INTACK, push_valid, push_data, jump_valid, jump_addr
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// CPU-side interrupt entry sequencer: acknowledge, latch vector, push return PC, jump.
// Optional feature macro NESTED_INT_EN: 2-bit nesting depth instead of a single in_isr bit.
module interrupt_sequencer #(
    parameter int                ADDR_W          = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE        = 16'h0010,
    parameter int                VEC_STRIDE_LOG2 = 2,
    parameter int                ACK_CYCLES      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    interrupt_sequencer_if.master bus,
    input  logic                  instr_bound,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic                  ie_set,
    input  logic                  ie_clr,
    input  logic                  reti,
    output logic                  busy,
    output logic                  in_isr,
    output logic                  ie
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_LATCH = 3'd2,
        S_PUSH  = 3'd3,
        S_JUMP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        ack_cnt_q, ack_cnt_d;
    logic              intack_q, intack_d;
    logic              push_valid_q, push_valid_d;
    logic [ADDR_W-1:0] push_data_q, push_data_d;
    logic              jump_valid_q, jump_valid_d;
    logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
    logic [2:0]        vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              ie_q, ie_d;
    logic              in_isr_q, in_isr_d;
    logic              accept_ok_s;
    logic              take_int_s;
    logic              reti_ok_s;
    logic              reti_restore_s;

`ifdef NESTED_INT_EN
    logic [1:0]        depth_q, depth_d;
`endif

    // Next-state, datapath and flag computation.
    always_comb begin
        state_d      = state_q;
        ack_cnt_d    = ack_cnt_q;
        intack_d     = intack_q;
        push_valid_d = push_valid_q;
        push_data_d  = push_data_q;
        jump_valid_d = 1'b0;
        jump_addr_d  = jump_addr_q;
        vec_d        = vec_q;

`ifdef NESTED_INT_EN
        accept_ok_s    = (depth_q != 2'd3);
        reti_restore_s = (depth_q == 2'd1);
`else
        accept_ok_s    = !in_isr_q;
        reti_restore_s = 1'b1;
`endif
        take_int_s = (state_q == S_IDLE) && bus.INT && ie_q && instr_bound && accept_ok_s;
        // A taken interrupt wins over a coincident reti at the same boundary.
        reti_ok_s  = reti && in_isr_q && (state_q == S_IDLE) && !take_int_s;

        case (state_q)
            S_IDLE: begin
                if (take_int_s) begin
                    state_d     = S_ACK;
                    push_data_d = pc_in;
                    ack_cnt_d   = 4'(ACK_CYCLES);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                // First ACK cycle keeps INTACK low so it rises one edge after entry.
                if (ack_cnt_q != 4'd0) begin
                    intack_d  = 1'b1;
                    ack_cnt_d = ack_cnt_q - 4'd1;
                end else begin
                    intack_d = 1'b0;
                    state_d  = S_LATCH;
                end
            end
            S_LATCH: begin
                vec_d        = bus.INTV;
                jump_addr_d  = VEC_BASE + (ADDR_W'(bus.INTV) << VEC_STRIDE_LOG2);
                push_valid_d = 1'b1;
                state_d      = S_PUSH;
            end
            S_PUSH: begin
                if (bus.push_ready) begin
                    push_valid_d = 1'b0;
                    jump_valid_d = 1'b1;
                    state_d      = S_JUMP;
                end else begin
                    push_valid_d = 1'b1;
                end
            end
            S_JUMP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                intack_d     = 1'b0;
                push_valid_d = 1'b0;
                ack_cnt_d    = 4'd0;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        if (take_int_s) begin
            ie_d = 1'b0;
        end else if (ie_clr) begin
            ie_d = 1'b0;
        end else if (ie_set) begin
            ie_d = 1'b1;
        end else if (reti_ok_s && reti_restore_s) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end

`ifdef NESTED_INT_EN
        if (take_int_s) begin
            depth_d = depth_q + 2'd1;
        end else if (reti_ok_s) begin
            depth_d = depth_q - 2'd1;
        end else begin
            depth_d = depth_q;
        end
        in_isr_d = (depth_d != 2'd0);
`else
        if (take_int_s) begin
            in_isr_d = 1'b1;
        end else if (reti_ok_s) begin
            in_isr_d = 1'b0;
        end else begin
            in_isr_d = in_isr_q;
        end
`endif
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ack_cnt_q    <= 4'd0;
            intack_q     <= 1'b0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            jump_valid_q <= 1'b0;
            jump_addr_q  <= '0;
            vec_q        <= 3'd0;
            busy_q       <= 1'b0;
            ie_q         <= 1'b0;
            in_isr_q     <= 1'b0;
`ifdef NESTED_INT_EN
            depth_q      <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            ack_cnt_q    <= ack_cnt_d;
            intack_q     <= intack_d;
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            jump_valid_q <= jump_valid_d;
            jump_addr_q  <= jump_addr_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            ie_q         <= ie_d;
            in_isr_q     <= in_isr_d;
`ifdef NESTED_INT_EN
            depth_q      <= depth_d;
`endif
        end
    end

    assign bus.INTACK     = intack_q;
    assign bus.push_valid = push_valid_q;
    assign bus.push_data  = push_data_q;
    assign bus.jump_valid = jump_valid_q;
    assign bus.jump_addr  = jump_addr_q;
    assign busy           = busy_q;
    assign in_isr         = in_isr_q;
    assign ie             = ie_q;

endmodule
